i2c_tx: RTL and testbench

//  Byte transmitter for the I2C datapath; the transmit-side partner of the i2c_rx byte receiver.

---
 rtl/i2c_tx.sv | 130 +++++++++++++
 tb/tb_i2c_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_tx.sv
// I2C byte transmitter: serialises a loaded word on SDA while SCL is low, optionally samples ACK.
// Define I2C_TX_ACK_EN to include the 9th-bit ACK/NACK sampling state.
module i2c_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              _rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic              tx_en_i,
  input  logic              tx_write_i,
  input  logic [DATA_W-1:0] tx_i,
  output logic              sda_o,
  output logic              busy_o,
  output logic              txdone_o,
  output logic              nack_o
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bcount_q, bcount_d;
  logic              scl_t_q;
  logic              rise, fall;
  logic [DATA_W-1:0] shreg_shifted;

  assign rise = ~scl_t_q & scl_i;
  assign fall = scl_t_q & ~scl_i;

  assign shreg_shifted = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0}
                                   : {1'b0, shreg_q[DATA_W-1:1]};

`ifdef I2C_TX_ACK_EN
  logic nack_q, nack_d;
  assign nack_o = nack_q;
`else
  logic unused_sda;
  assign unused_sda = sda_i;
  assign nack_o     = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge _rst_i) begin
    if (!_rst_i) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bcount_q <= '0;
      scl_t_q  <= 1'b1;
`ifdef I2C_TX_ACK_EN
      nack_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bcount_q <= bcount_d;
      scl_t_q  <= scl_i;
`ifdef I2C_TX_ACK_EN
      nack_q   <= nack_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bcount_d = bcount_q;
`ifdef I2C_TX_ACK_EN
    nack_d   = nack_q;
`endif
    // Disable overrides every active state; nack is intentionally left untouched.
    if (state_q != IDLE && !tx_en_i) begin
      state_d  = IDLE;
      bcount_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tx_write_i && tx_en_i && !scl_i) begin
            shreg_d  = tx_i;
            bcount_d = '0;
`ifdef I2C_TX_ACK_EN
            nack_d   = 1'b0;
`endif
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            shreg_d = shreg_shifted;
            if (bcount_q == LAST_BIT) begin
              bcount_d = '0;
`ifdef I2C_TX_ACK_EN
              state_d  = ACK;
`else
              state_d  = DONE;
`endif
            end else begin
              bcount_d = bcount_q + CNT_W'(1);
            end
          end
        end
`ifdef I2C_TX_ACK_EN
        ACK: begin
          if (rise)      nack_d  = sda_i;
          else if (fall) state_d = DONE;
        end
`endif
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sda_o = 1'b1;
    if (state_q == SHIFT) sda_o = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
  end

  assign busy_o   = (state_q != IDLE);
  assign txdone_o = (state_q == DONE);

endmodule

// File: tb/tb_i2c_tx.sv
// Self-checking bench for i2c_tx: MSB-first and LSB-first instances, scoreboard of SDA bits seen at SCL rises.
module tb_i2c_tx;

`ifdef I2C_TX_ACK_EN
  localparam logic ACKB = 1'b1;
`else
  localparam logic ACKB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b0;
  logic       sda_in = 1'b1;
  logic       en = 1'b1;
  logic       wr_m = 1'b0, wr_l = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sda_m, busy_m, done_m, nack_m;
  logic       sda_l, busy_l, done_l, nack_l;
  logic       sel = 1'b0;

  int errors = 0;
  int checks = 0;
  int done_cnt_m = 0, done_cnt_l = 0;
  logic sb[$];

  always #5 clk = ~clk;

  i2c_tx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), ._rst_i(rst_n), .scl_i(scl), .sda_i(sda_in), .tx_en_i(en),
    .tx_write_i(wr_m), .tx_i(tx_data), .sda_o(sda_m), .busy_o(busy_m),
    .txdone_o(done_m), .nack_o(nack_m));

  i2c_tx #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), ._rst_i(rst_n), .scl_i(scl), .sda_i(sda_in), .tx_en_i(en),
    .tx_write_i(wr_l), .tx_i(tx_data), .sda_o(sda_l), .busy_o(busy_l),
    .txdone_o(done_l), .nack_o(nack_l));

  always @(posedge clk) begin
    if (done_m) done_cnt_m++;
    if (done_l) done_cnt_l++;
  end

  function automatic logic cur_sda();  return sel ? sda_l  : sda_m;  endfunction
  function automatic logic cur_busy(); return sel ? busy_l : busy_m; endfunction
  function automatic logic cur_done(); return sel ? done_l : done_m; endfunction
  function automatic logic cur_nack(); return sel ? nack_l : nack_m; endfunction
  function automatic int   cur_cnt();  return sel ? done_cnt_l : done_cnt_m; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_raw();
    clk_n(4); scl = 1'b1;
    clk_n(4); scl = 1'b0;
  endtask

  task automatic scl_pulse(input logic ack_bit, input bit is_ack);
    logic exp;
    clk_n(4);
    if (is_ack) sda_in = ack_bit;
    scl = 1'b1;
    if (is_ack) check("ack_sda_released", cur_sda(), 1);
    else if (sb.size() == 0) check("sb_underflow", 1, 0);
    else begin
      exp = sb.pop_front();
      check("sda_bit", cur_sda(), exp);
    end
    clk_n(4);
    scl = 1'b0;
    sda_in = 1'b1;
  endtask

  task automatic start_write(input logic [7:0] d, input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) sb.push_back(seq[i]);
    tx_data = d;
    if (sel) wr_l = 1'b1; else wr_m = 1'b1;
    clk_n(1);
    wr_l = 1'b0; wr_m = 1'b0;
    check("busy_after_accept", cur_busy(), 1);
    check("nack_cleared_on_accept", cur_nack(), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
    logic       sel;
    logic       ack_bit;
    logic       exp_nack;
    int         wr_after;
    int         abort_after;
    bit         wr_in_done;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int   cnt0;
    bit   seen;
    sel  = v.sel;
    cnt0 = cur_cnt();
    start_write(v.data, v.seq);
    for (int p = 0; p < 8; p++) begin
      scl_pulse(1'b1, 1'b0);
      if (p + 1 == v.wr_after) begin
        tx_data = 8'h00;
        if (sel) wr_l = 1'b1; else wr_m = 1'b1;
        clk_n(1);
        wr_l = 1'b0; wr_m = 1'b0;
      end
      if (p + 1 == v.abort_after) begin
        clk_n(1);
        en = 1'b0;
        clk_n(1);
        check("abort_sda", cur_sda(), 1);
        check("abort_busy", cur_busy(), 0);
        sb.delete();
        scl_raw(); scl_raw(); scl_raw(); scl_raw();
        check("abort_no_done", cur_cnt() - cnt0, 0);
        en = 1'b1;
        clk_n(2);
        return;
      end
    end
`ifdef I2C_TX_ACK_EN
    scl_pulse(v.ack_bit, 1'b1);
`endif
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      clk_n(1);
      if (cur_done()) begin
        seen = 1'b1;
        check("nack_at_done", cur_nack(), v.exp_nack);
        if (v.wr_in_done) begin
          tx_data = 8'hFF;
          if (sel) wr_l = 1'b1; else wr_m = 1'b1;
        end
      end
    end
    check("txdone_seen", seen, 1);
    clk_n(1);
    wr_l = 1'b0; wr_m = 1'b0;
    check("done_one_cycle", cur_done(), 0);
    check("idle_after_done", cur_busy(), 0);
    clk_n(2);
    check("done_pulse_count", cur_cnt() - cnt0, 1);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    //           data   seq(first sent=bit7) sel  ack   exp_nack     wr  abt  wrdone
    vecs[0] = '{8'hA5, 8'b10100101, 1'b0, 1'b0, 1'b0,        0,  0,  1'b1};
    vecs[1] = '{8'h3C, 8'b00111100, 1'b0, 1'b1, ACKB,        0,  0,  1'b0};
    vecs[2] = '{8'hFF, 8'b11111111, 1'b0, 1'b0, 1'b0,        3,  0,  1'b0};
    vecs[3] = '{8'h5A, 8'b01011010, 1'b0, 1'b0, 1'b0,        0,  4,  1'b0};
    vecs[4] = '{8'h81, 8'b10000001, 1'b0, 1'b0, 1'b0,        0,  0,  1'b0};
    vecs[5] = '{8'h01, 8'b10000000, 1'b1, 1'b0, 1'b0,        0,  0,  1'b0};
    vecs[6] = '{8'hC4, 8'b00100011, 1'b1, 1'b1, ACKB,        0,  0,  1'b0};

    clk_n(2);
    check("rst_sda", sda_m, 1);
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_nack", nack_m, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clk_n(1);
      check("idle_hold", {sda_m, busy_m, done_m, sda_l, busy_l, done_l}, 6'b100100);
    end

    // Write while SCL is high must be ignored.
    scl = 1'b1;
    wr_m = 1'b1; tx_data = 8'h55;
    clk_n(1);
    wr_m = 1'b0;
    clk_n(1);
    check("write_scl_high_ignored", busy_m, 0);
    scl = 1'b0;
    clk_n(2);

    for (int v = 0; v < 7; v++) begin
      run_vec(vecs[v]);
      if (v == 1) begin
        clk_n(10);
        check("nack_hold", nack_m, ACKB);
      end
    end

    // Asynchronous reset mid-transfer releases SDA without a clock edge.
    sel = 1'b0;
    start_write(8'h00, 8'h00);
    scl_pulse(1'b1, 1'b0);
    check("sda_low_before_reset", sda_m, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sda", sda_m, 1);
    check("async_rst_busy", busy_m, 0);
    sb.delete();
    clk_n(2);
    rst_n = 1'b1;
    clk_n(2);
    check("post_rst_idle", busy_m, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
